// File: rtl/aes_pkg.sv
// Shared AES-128 constants: widths, round count and the key-expansion sequencer's
// state encoding.
package aes_pkg;

    localparam int KEY_W         = 128;
    localparam int AES128_ROUNDS = 10;
    localparam int CNT_W         = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] EXPAND = 2'd2;
    localparam logic [1:0] READY  = 2'd3;

endpackage

// File: rtl/key_expansion_ctrl.sv
// Sequencer for the AES-128 round-key generator: takes a cipher key over valid/ready,
// walks the generator through rounds 0..10 and flags when k0..k10 are complete.
module key_expansion_ctrl
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = KEY_W,
    parameter int NUM_ROUNDS   = AES128_ROUNDS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BLOCK_LENGTH-1:0] key_in,
    input  logic                    key_valid,
    output logic                    key_ready,
    input  logic                    abort,
    input  logic                    pipe_busy,
    output logic [BLOCK_LENGTH-1:0] kg_key,
    output logic                    kg_en,
    output logic [CNT_W-1:0]        kg_round_count,
    output logic                    keys_valid,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [BLOCK_LENGTH-1:0] key_q, key_d;
    logic                    kg_en_q, kg_en_d;
    logic                    keys_valid_q, keys_valid_d;
    logic                    accept;

    // A key in use by the pipeline must not be displaced, so READY only offers
    // ready once the pipeline has drained.
    assign key_ready = (state_q == IDLE) | ((state_q == READY) & ~pipe_busy);
    assign accept    = key_valid & key_ready;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        count_d = count_q;
        key_d   = key_q;

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (accept) begin
                    state_d = LOAD;
                    key_d   = key_in;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    state_d = EXPAND;
                    count_d = CNT_W'(1);
                end
            end
            EXPAND: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_q == LAST_ROUND) begin
                    state_d = READY;
                    count_d = '0;
                end else if ((count_q == '0) || (count_q > LAST_ROUND)) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            READY: begin
                if (count_q != '0) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (accept) begin
                    state_d = LOAD;
                    key_d   = key_in;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        // Enable and valid flag follow the next state so they line up with it.
        kg_en_d      = (state_d == LOAD) | (state_d == EXPAND);
        keys_valid_d = (state_d == READY);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            key_q        <= '0;
            kg_en_q      <= 1'b0;
            keys_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            key_q        <= key_d;
            kg_en_q      <= kg_en_d;
            keys_valid_q <= keys_valid_d;
        end
    end

    assign kg_key         = key_q;
    assign kg_en          = kg_en_q;
    assign kg_round_count = count_q;
    assign keys_valid     = keys_valid_q;
    assign busy           = (state_q == LOAD) | (state_q == EXPAND);

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Bench for key_expansion_ctrl: directed scenarios then random traffic, checked against a
// progress-counter reference model and a behavioural AES-128 round-key generator.
module tb_key_expansion_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         abort;
    logic         pipe_busy;
    logic [127:0] kg_key;
    logic         kg_en;
    logic [3:0]   kg_round_count;
    logic         keys_valid;
    logic         busy;

    int checks = 0;
    int errors = 0;

    key_expansion_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key_in),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .abort          (abort),
        .pipe_busy      (pipe_busy),
        .kg_key         (kg_key),
        .kg_en          (kg_en),
        .kg_round_count (kg_round_count),
        .keys_valid     (keys_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference model: phase -1 = idle, 0..10 = round being generated, 11 = all keys ready.
    int           phase;
    logic [127:0] m_key;

    // Behavioural stand-in for key_generator, fed by the controller's outputs.
    logic [7:0]   sbox [256];
    logic [127:0] rk [11];
    logic         g_en;
    logic [3:0]   g_rc;
    logic [127:0] g_key;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] l = x << n;
        logic [7:0] r = x >> (8 - n);
        return l | r;
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            if (a != 0) begin
                for (int b = 1; b < 256; b++)
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] rcon_of(input int r);
        logic [7:0] c = 8'h01;
        for (int i = 1; i < r; i++) c = xtime(c);
        return c;
    endfunction

    function automatic logic [127:0] next_round_key(input logic [127:0] prev, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;
        w0  = prev[127:96];
        w1  = prev[95:64];
        w2  = prev[63:32];
        w3  = prev[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox[rot[31:24]], sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]};
        t   = sub ^ {rcon, 24'h000000};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] full_k10(input logic [127:0] key);
        logic [127:0] k = key;
        for (int r = 1; r <= 10; r++) k = next_round_key(k, rcon_of(r));
        return k;
    endfunction

    function automatic logic exp_ready();
        return (phase == -1) || ((phase == 11) && !pipe_busy);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic in_flight = (phase >= 0) && (phase <= 10);
        check("kg_en", kg_en, in_flight);
        check("kg_round_count", kg_round_count, in_flight ? phase[3:0] : 4'd0);
        check("keys_valid", keys_valid, phase == 11);
        check("busy", busy, in_flight);
        check("kg_key", kg_key, m_key);
        check("key_ready", key_ready, exp_ready());
    endtask

    // One clock: check comb ready, capture generator inputs, step model at the edge, check.
    task automatic tick();
        logic acc;
        #1;
        check("key_ready_comb", key_ready, exp_ready());
        g_en  = kg_en;
        g_rc  = kg_round_count;
        g_key = kg_key;
        acc   = key_valid && exp_ready();
        @(posedge clk);
        if (rst) begin
            phase = -1;
            m_key = '0;
        end else if ((phase >= 0) && (phase <= 10) && abort) begin
            phase = -1;
        end else if (acc) begin
            phase = 0;
            m_key = key_in;
        end else if ((phase >= 0) && (phase <= 10)) begin
            phase++;
        end
        if (g_en) begin
            if (g_rc == 4'd0) rk[0] = g_key;
            else if (g_rc <= 4'd10) rk[g_rc] = next_round_key(rk[g_rc - 4'd1], rcon_of(int'(g_rc)));
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    initial begin
        logic [3:0]   trace [$];
        logic [127:0] k3, k4;

        rst = 1'b1; key_valid = 1'b0; key_in = '0; abort = 1'b0; pipe_busy = 1'b0;
        phase = -1; m_key = '0;
        for (int i = 0; i < 11; i++) rk[i] = '0;
        build_sbox();

        // Reset, then FIPS-197 key; kg_en must run for exactly rounds 0..10.
        tick();
        tick();
        rst = 1'b0;
        key_in = K1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0; key_in = rand_key();
        if (kg_en) trace.push_back(kg_round_count);
        for (int i = 0; i < 11; i++) begin
            tick();
            if (kg_en) trace.push_back(kg_round_count);
        end
        check("keys_valid_12th_cycle", keys_valid, 1'b1);
        check("k1", rk[1], K1_R1);
        check("k10", rk[10], K1_R10);
        check("trace_len", 128'(trace.size()), 128'd11);
        for (int i = 0; i < trace.size(); i++) check("trace_round", trace[i], 128'(i));
        tick();

        // Re-key with K1; a second key offered mid-expansion must wait for READY.
        key_in = K1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int n = 0; n < 20 && phase != 4; n++) tick();
        key_in = K2; key_valid = 1'b1;
        for (int n = 0; n < 20 && phase != 11; n++) tick();
        check("held_key_k10", rk[10], K1_R10);
        check("held_key_kg_key", kg_key, K1);
        check("first_ready_key_ready", key_ready, 1'b1);
        tick();
        check("rekey_taken", kg_key, K2);
        key_valid = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("k2_k10", rk[10], K2_R10);

        // READY with the pipeline busy: key held off until the pipeline drains.
        k3 = rand_key();
        key_in = k3; key_valid = 1'b1; pipe_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("busy_pipe_keys_valid", keys_valid, 1'b1);
            check("busy_pipe_kg_key", kg_key, K2);
        end
        pipe_busy = 1'b0;
        tick();
        check("drain_keys_valid", keys_valid, 1'b0);
        check("drain_kg_key", kg_key, k3);
        key_valid = 1'b0;

        // Abort during round 6, then a fresh key completes normally.
        for (int n = 0; n < 20 && phase != 6; n++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_kg_en", kg_en, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_keys_valid", keys_valid, 1'b0);
        check("abort_key_retained", kg_key, k3);
        key_in = K1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("after_abort_keys_valid", keys_valid, 1'b1);
        check("after_abort_k10", rk[10], K1_R10);

        // Reset during round 3 with a key offered in the same cycle.
        key_in = k3; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int n = 0; n < 20 && phase != 3; n++) tick();
        k4 = rand_key();
        rst = 1'b1; key_valid = 1'b1; key_in = k4;
        tick();
        check("rst_kg_key", kg_key, 128'd0);
        check("rst_kg_en", kg_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Abort together with a key in IDLE: key is still taken.
        abort = 1'b1;
        tick();
        abort = 1'b0; key_valid = 1'b0;
        check("idle_abort_accept_key", kg_key, k4);
        check("idle_abort_accept_en", kg_en, 1'b1);

        // Random traffic against the model; k10 must match kg_key whenever ready.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            key_valid = ($urandom_range(0, 2) == 0);
            abort     = ($urandom_range(0, 7) == 0);
            pipe_busy = $urandom_range(0, 1) == 1;
            key_in    = rand_key();
            tick();
            if (phase == 11) check("rand_k10", rk[10], full_k10(m_key));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
